measure_multi: RTL and testbench

Parametrised multi-channel latency measurement block, the successor to the single-channel `measure` unit. It sits in the `clock` domain between the sensor front-ends and the BCD/video path. A shared `start` pulse arms every channel, and each channel times the interval until its own `sensor_trigger` pulse. Per channel it keeps current, minimum, maximum and a sliding-window average, all in binary; it also provides timeout detection and a synchronous statistics clear.

---
 rtl/measure_multi.sv | 168 ++++++++++++++++
 tb/tb_measure_multi.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/measure_multi.sv
// Multi-channel latency timer: one shared prescaled timebase, per-channel
// arm/stop FSM with current/min/max and a ring-buffer sliding average.
module measure_multi #(
  parameter int CHANNELS  = 1,
  parameter int CNT_WIDTH = 17,
  parameter int TICK_DIV  = 2700,
  parameter int AVG_LOG2  = 3,
  parameter int TIMEOUT   = 99999
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          clear,
  input  logic [CHANNELS-1:0]           sensor_trigger,
  output logic [CHANNELS-1:0]           busy,
  output logic [CHANNELS-1:0]           sample_valid,
  output logic [CHANNELS-1:0]           timeout,
  output logic [CHANNELS*CNT_WIDTH-1:0] lat_current,
  output logic [CHANNELS*CNT_WIDTH-1:0] lat_minimum,
  output logic [CHANNELS*CNT_WIDTH-1:0] lat_maximum,
  output logic [CHANNELS*CNT_WIDTH-1:0] lat_average
);

  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = CNT_WIDTH + AVG_LOG2;

  localparam logic [PW-1:0]        PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] UNITS_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT);

  typedef enum logic {IDLE, ARMED} state_e;

  logic [PW-1:0]        presc_q, presc_d;
  logic [CNT_WIDTH-1:0] units_q, units_d;

  always_comb begin
    presc_d = presc_q;
    units_d = units_q;
    if (start) begin
      presc_d = '0;
      units_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (units_q != UNITS_MAX) units_d = units_q + CNT_WIDTH'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      units_q <= '0;
    end else begin
      presc_q <= presc_d;
      units_q <= units_d;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    state_e               state_q, state_d;
    logic                 accept, expire;
    logic [CNT_WIDTH-1:0] cur_q, cur_d, min_q, min_d, max_q, max_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [AVG_LOG2-1:0]  ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] buf_q [DEPTH];
    logic [CNT_WIDTH-1:0] buf_d [DEPTH];
    logic                 first_q, first_d;
    logic                 valid_q, valid_d;
    logic                 tmo_q, tmo_d;

    // Precedence: clear, then start (re-arm discards), then trigger, then timeout.
    always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      expire  = 1'b0;
      if (clear) begin
        state_d = IDLE;
      end else if (start) begin
        state_d = ARMED;
      end else if (state_q == ARMED) begin
        if (sensor_trigger[n]) begin
          accept  = 1'b1;
          state_d = IDLE;
        end else if (units_q == TIMEOUT_VAL) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
    end

    always_comb begin
      cur_d   = cur_q;
      min_d   = min_q;
      max_d   = max_q;
      sum_d   = sum_q;
      ptr_d   = ptr_q;
      first_d = first_q;
      valid_d = accept;
      tmo_d   = expire;
      for (int i = 0; i < DEPTH; i++) buf_d[i] = buf_q[i];
      if (clear) begin
        cur_d   = '0;
        min_d   = '0;
        max_d   = '0;
        sum_d   = '0;
        ptr_d   = '0;
        first_d = 1'b1;
        for (int i = 0; i < DEPTH; i++) buf_d[i] = '0;
      end else if (accept) begin
        cur_d = units_q;
        if (first_q) begin
          // Seed the whole window so the average is meaningful from sample one.
          min_d   = units_q;
          max_d   = units_q;
          sum_d   = SW'(units_q) << AVG_LOG2;
          first_d = 1'b0;
          for (int i = 0; i < DEPTH; i++) buf_d[i] = units_q;
        end else begin
          min_d        = (units_q < min_q) ? units_q : min_q;
          max_d        = (units_q > max_q) ? units_q : max_q;
          sum_d        = sum_q - SW'(buf_q[ptr_q]) + SW'(units_q);
          buf_d[ptr_q] = units_q;
          ptr_d        = ptr_q + AVG_LOG2'(1);
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cur_q   <= '0;
        min_q   <= '0;
        max_q   <= '0;
        sum_q   <= '0;
        ptr_q   <= '0;
        first_q <= 1'b1;
        valid_q <= 1'b0;
        tmo_q   <= 1'b0;
        for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      end else begin
        cur_q   <= cur_d;
        min_q   <= min_d;
        max_q   <= max_d;
        sum_q   <= sum_d;
        ptr_q   <= ptr_d;
        first_q <= first_d;
        valid_q <= valid_d;
        tmo_q   <= tmo_d;
        for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
      end
    end

    assign busy[n]         = (state_q == ARMED);
    assign sample_valid[n] = valid_q;
    assign timeout[n]      = tmo_q;
    assign lat_current[n*CNT_WIDTH +: CNT_WIDTH] = cur_q;
    assign lat_minimum[n*CNT_WIDTH +: CNT_WIDTH] = min_q;
    assign lat_maximum[n*CNT_WIDTH +: CNT_WIDTH] = max_q;
    assign lat_average[n*CNT_WIDTH +: CNT_WIDTH] = sum_q[SW-1:AVG_LOG2];
  end

endmodule

// File: tb/tb_measure_multi.sv
// Directed bench for measure_multi: a 2-channel instance for the main
// behaviour and a 1-channel fast-tick instance for units saturation.
module tb_measure_multi;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, clear;
  logic [1:0]  trig, busy, sv, tmo;
  logic [15:0] cur, mn, mx, avg;

  logic        startB, clearB;
  logic [0:0]  trigB, busyB, svB, tmoB;
  logic [7:0]  curB, mnB, mxB, avgB;

  int checks = 0;
  int errors = 0;

  measure_multi #(.CHANNELS(2), .CNT_WIDTH(8), .TICK_DIV(4), .AVG_LOG2(2), .TIMEOUT(20)) dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear), .sensor_trigger(trig),
    .busy(busy), .sample_valid(sv), .timeout(tmo),
    .lat_current(cur), .lat_minimum(mn), .lat_maximum(mx), .lat_average(avg));

  measure_multi #(.CHANNELS(1), .CNT_WIDTH(8), .TICK_DIV(1), .AVG_LOG2(2), .TIMEOUT(255)) dutB (
    .clock(clock), .reset(reset), .start(startB), .clear(clearB), .sensor_trigger(trigB),
    .busy(busyB), .sample_valid(svB), .timeout(tmoB),
    .lat_current(curB), .lat_minimum(mnB), .lat_maximum(mxB), .lat_average(avgB));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] lane(input logic [15:0] bus, input int ch);
    return bus[ch*8 +: 8];
  endfunction

  task automatic checkChannel(input string tag, input int ch, input int c, input int lo, input int hi, input int a);
    checkOutput({tag, "_cur"}, 32'(lane(cur, ch)), 32'(c));
    checkOutput({tag, "_min"}, 32'(lane(mn, ch)),  32'(lo));
    checkOutput({tag, "_max"}, 32'(lane(mx, ch)),  32'(hi));
    checkOutput({tag, "_avg"}, 32'(lane(avg, ch)), 32'(a));
  endtask

  // Start, then trigger channel ch while units == v; returns in the cycle after.
  task automatic applyStimulus(input int ch, input int v);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (v * 4) @(negedge clock);
    trig[ch] = 1'b1;
    @(negedge clock) trig = '0;
  endtask

  initial begin
    int samples [6];
    int avgs [6];
    samples = '{10, 12, 14, 16, 18, 20};
    avgs    = '{10, 10, 11, 13, 15, 17};
    reset = 1'b0; start = 1'b0; clear = 1'b0; trig = '0;
    startB = 1'b0; clearB = 1'b0; trigB = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset_busy", 32'(busy), 0);
    checkChannel("reset_ch0", 0, 0, 0, 0, 0);
    @(negedge clock) reset = 1'b1;

    // 1: asynchronous reset mid-measurement
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("armed_busy", 32'(busy), 3);
    #2 reset = 1'b0;
    #1 checkOutput("async_reset_busy", 32'(busy), 0);
    checkOutput("async_reset_sv", 32'(sv), 0);
    @(negedge clock) reset = 1'b1;
    @(negedge clock) trig = 2'b11;
    @(negedge clock) trig = '0;
    checkOutput("idle_trig_busy", 32'(busy), 0);
    checkOutput("idle_trig_sv", 32'(sv), 0);
    checkOutput("idle_trig_cur", 32'(cur), 0);

    // 2: first sample on ch0
    applyStimulus(0, 7);
    checkOutput("s7_sv", 32'(sv), 1);
    checkOutput("s7_busy", 32'(busy), 2);
    checkChannel("s7_ch0", 0, 7, 7, 7, 7);
    checkChannel("s7_ch1", 1, 0, 0, 0, 0);
    @(negedge clock) checkOutput("s7_sv_pulse", 32'(sv), 0);

    // 3: min/max/average progression
    applyStimulus(0, 3);
    checkChannel("s3", 0, 3, 3, 7, 6);
    applyStimulus(0, 11);
    checkChannel("s11", 0, 11, 3, 11, 7);
    applyStimulus(0, 5);
    checkChannel("s5", 0, 5, 3, 11, 6);

    // 4: timeout, then trigger exactly at TIMEOUT
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (80) @(negedge clock);
    checkOutput("pre_tmo", 32'(tmo), 0);
    checkOutput("pre_tmo_busy", 32'(busy), 3);
    @(negedge clock);
    checkOutput("tmo", 32'(tmo), 3);
    checkOutput("tmo_busy", 32'(busy), 0);
    checkOutput("tmo_sv", 32'(sv), 0);
    checkChannel("tmo_ch0", 0, 5, 3, 11, 6);
    checkChannel("tmo_ch1", 1, 0, 0, 0, 0);
    @(negedge clock) checkOutput("tmo_pulse", 32'(tmo), 0);
    applyStimulus(1, 20);
    checkOutput("t20_sv", 32'(sv), 2);
    checkOutput("t20_tmo", 32'(tmo), 1);
    checkChannel("t20_ch1", 1, 20, 20, 20, 20);

    // 5: start beats trigger, clear beats trigger
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (20) @(negedge clock);
    start = 1'b1; trig = 2'b01;
    @(negedge clock) begin start = 1'b0; trig = '0; end
    checkOutput("restart_sv", 32'(sv), 0);
    checkOutput("restart_busy", 32'(busy), 3);
    repeat (12) @(negedge clock);
    trig = 2'b01;
    @(negedge clock) trig = '0;
    checkOutput("rearm_sv", 32'(sv), 1);
    checkChannel("rearm", 0, 3, 3, 11, 5);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (16) @(negedge clock);
    clear = 1'b1; trig = 2'b11;
    @(negedge clock) begin clear = 1'b0; trig = '0; end
    checkOutput("clr_sv", 32'(sv), 0);
    checkOutput("clr_busy", 32'(busy), 0);
    checkOutput("clr_tmo", 32'(tmo), 0);
    checkOutput("clr_cur", 32'(cur), 0);
    checkOutput("clr_min", 32'(mn), 0);
    checkOutput("clr_max", 32'(mx), 0);
    checkOutput("clr_avg", 32'(avg), 0);
    applyStimulus(0, 9);
    checkChannel("post_clr", 0, 9, 9, 9, 9);

    // 6: window wrap after clear
    @(negedge clock) clear = 1'b1;
    @(negedge clock) clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, samples[i]);
      checkOutput($sformatf("wrap_avg%0d", i), 32'(lane(avg, 0)), 32'(avgs[i]));
    end
    checkChannel("wrap_end", 0, 20, 10, 20, 17);

    // 6b: saturation on the fast-tick instance
    @(negedge clock) startB = 1'b1;
    @(negedge clock) startB = 1'b0;
    repeat (255) @(negedge clock);
    trigB = 1'b1;
    @(negedge clock) trigB = 1'b0;
    checkOutput("b255_sv", 32'(svB), 1);
    checkOutput("b255_tmo", 32'(tmoB), 0);
    checkOutput("b255_cur", 32'(curB), 255);
    @(negedge clock) startB = 1'b1;
    @(negedge clock) startB = 1'b0;
    repeat (256) @(negedge clock);
    checkOutput("b_tmo", 32'(tmoB), 1);
    repeat (20) @(negedge clock);
    checkOutput("b_units_sat", 32'(dutB.units_q), 255);
    checkOutput("b_busy", 32'(busyB), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
